// File: rtl/fpro_bus_arbiter.sv
// Two-master FPro bus arbiter and transaction sequencer.
// Grants M0 or M1 and issues a single-cycle read or write strobe. Address and
// chip select are held until the read data is captured, then the granted master
// gets a one-cycle ack.
// Build option: define FPRO_ARB_FIXED_PRIO_EN to make M0 win every tie.
// Without it (the default), ties alternate round-robin using last_grant.
module fpro_bus_arbiter #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    // master 0
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_video,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    // master 1
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_video,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    // FPro fabric
    output logic [ADDR_W-1:0] fp_addr,
    output logic [DATA_W-1:0] fp_write_data,
    output logic              fp_write,
    output logic              fp_read,
    output logic              fp_mmio_cs,
    output logic              fp_video_cs,
    input  logic [DATA_W-1:0] fp_read_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    // WAIT runs RD_LAT cycles; the counter counts down to zero inclusive
    localparam logic [2:0] CntInit = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;          // 0 = M0, 1 = M1
    logic              last_grant_q, last_grant_d;
    logic              wr_q, wr_d;
    logic              video_q, video_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              capture;
    logic              pick_m1;
    logic              busy;

`ifdef FPRO_ARB_FIXED_PRIO_EN
    // Tie goes to M0 unconditionally
    assign pick_m1 = m1_req & ~m0_req;
`else
    // Tie goes to whichever master was not granted last
    assign pick_m1 = m1_req & (~m0_req | ~last_grant_q);
`endif

    // Next-state logic: arbitration in IDLE, strobe/wait sequencing afterwards
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        video_d      = video_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        capture      = 1'b0;

        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    grant_d = pick_m1;
                    wr_d    = pick_m1 ? m1_wr    : m0_wr;
                    video_d = pick_m1 ? m1_video : m0_video;
                    addr_d  = pick_m1 ? m1_addr  : m0_addr;
                    wdata_d = pick_m1 ? m1_wdata : m0_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (wr_q) begin
                    state_d = StDone;
                end else if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Read data lands directly in the granted master's return register
        if (capture) begin
            if (grant_q) begin
                m1_rdata_d = fp_read_data;
            end else begin
                m0_rdata_d = fp_read_data;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            video_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 3'd0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            video_q      <= video_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Strobes, chip selects and acks decoded from the registered state
    assign busy          = (state_q != StIdle);
    assign fp_write      = (state_q == StIssue) & wr_q;
    assign fp_read       = (state_q == StIssue) & ~wr_q;
    assign fp_mmio_cs    = busy & ~video_q;
    assign fp_video_cs   = busy & video_q;
    assign m0_ack        = (state_q == StDone) & ~grant_q;
    assign m1_ack        = (state_q == StDone) & grant_q;
    assign fp_addr       = addr_q;
    assign fp_write_data = wdata_q;
    assign m0_rdata      = m0_rdata_q;
    assign m1_rdata      = m1_rdata_q;

endmodule
